// File: rtl/reaction_pkg.sv
// Shared types and default timing for the reaction-timer sequencer.
// Holds the state encoding, LED count and a thermometer-code helper.
// Pure declarations; no logic or state.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LIGHT,
    DELAY,
    REACT,
    SHOW,
    FALSE
  } state_t;

  localparam int NUM_LEDS         = 10;
  localparam int DEF_LFSR_W       = 7;
  localparam int DEF_STEP_MS      = 500;
  localparam int DEF_MIN_DELAY_MS = 250;
  localparam int DEF_DELAY_SHIFT  = 4;
  localparam int DEF_MAX_MS       = 9999;
  localparam int DEF_CNT_W        = 14;

  // Thermometer code: the n lowest LEDs lit, LSB first.
  function automatic logic [NUM_LEDS-1:0] therm(input logic [3:0] n);
    logic [NUM_LEDS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      v[i] = (i < int'(n));
    end
    return v;
  endfunction

endpackage

// File: rtl/reaction_ctrl_if.sv
// Bundles the game-side signals of the reaction sequencer.
// master = environment (tick, key, LFSR), slave = sequencer.
// No flow control: strobes and levels only.
interface reaction_ctrl_if #(
  parameter int LFSR_W = 7,
  parameter int CNT_W  = 14
);
  import reaction_pkg::*;

  logic                tick_ms;
  logic                trigger_n;
  logic [LFSR_W-1:0]   lfsr_val;
  logic                en_lfsr;
  logic [NUM_LEDS-1:0] ledr;
  logic [CNT_W-1:0]    react_ms;
  logic                result_valid;
  logic                false_start;
  logic                timeout;
  logic                busy;

  modport master (
    output tick_ms, trigger_n, lfsr_val,
    input  en_lfsr, ledr, react_ms, result_valid, false_start, timeout, busy
  );

  modport slave (
    input  tick_ms, trigger_n, lfsr_val,
    output en_lfsr, ledr, react_ms, result_valid, false_start, timeout, busy
  );

endinterface

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for an async active-low key plus falling-edge pulse.
// Latency: press_o is high in the cycle after the 2nd edge that sees the key low.
// No backpressure; a held key yields exactly one pulse.
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  logic s1_q, s2_q, s3_q;

  // Sync chain plus one delayed copy for edge detection; resets to released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= key_n_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign press_o = s3_q & ~s2_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: LED countdown, random hold-off, ms reaction timing.
// Latency: press acts at the edge where the press pulse is high; outputs registered.
// No backpressure; tick_ms and the key are consumed as they arrive.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int LFSR_W       = DEF_LFSR_W,
  parameter int STEP_MS      = DEF_STEP_MS,
  parameter int MIN_DELAY_MS = DEF_MIN_DELAY_MS,
  parameter int DELAY_SHIFT  = DEF_DELAY_SHIFT,
  parameter int MAX_MS       = DEF_MAX_MS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  reaction_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_MS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_MS);
  localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_DELAY_MS);
  localparam logic [3:0]       LAST_STEP = 4'(NUM_LEDS);

  logic press;

  key_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_n_i (bus.trigger_n),
    .press_o (press)
  );

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    ms_cnt_q, ms_cnt_d;
  logic [CNT_W-1:0]    delay_cnt_q, delay_cnt_d;
  logic [CNT_W-1:0]    react_cnt_q, react_cnt_d;
  logic [CNT_W-1:0]    react_ms_q, react_ms_d;
  logic [3:0]          step_q, step_d;
  logic [NUM_LEDS-1:0] ledr_q, ledr_d;
  logic                en_lfsr_q, en_lfsr_d;
  logic                result_valid_q, result_valid_d;
  logic                false_start_q, false_start_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    delay_load;

  // Hold-off sampled from the LFSR at the moment the last LED step expires.
  assign delay_load = MIN_CNT + (CNT_W'(bus.lfsr_val) << DELAY_SHIFT);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ms_cnt_q       <= '0;
      delay_cnt_q    <= '0;
      react_cnt_q    <= '0;
      react_ms_q     <= '0;
      step_q         <= '0;
      ledr_q         <= '0;
      en_lfsr_q      <= 1'b1;
      result_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ms_cnt_q       <= ms_cnt_d;
      delay_cnt_q    <= delay_cnt_d;
      react_cnt_q    <= react_cnt_d;
      react_ms_q     <= react_ms_d;
      step_q         <= step_d;
      ledr_q         <= ledr_d;
      en_lfsr_q      <= en_lfsr_d;
      result_valid_q <= result_valid_d;
      false_start_q  <= false_start_d;
      timeout_q      <= timeout_d;
    end
  end

  // Next-state and next-output decode; a press always outranks a tick.
  always_comb begin
    state_d        = state_q;
    ms_cnt_d       = ms_cnt_q;
    delay_cnt_d    = delay_cnt_q;
    react_cnt_d    = react_cnt_q;
    react_ms_d     = react_ms_q;
    step_d         = step_q;
    ledr_d         = ledr_q;
    en_lfsr_d      = en_lfsr_q;
    result_valid_d = 1'b0;
    false_start_d  = false_start_q;
    timeout_d      = timeout_q;

    case (state_q)
      IDLE: begin
        if (press) begin
          state_d   = LIGHT;
          step_d    = '0;
          ms_cnt_d  = '0;
          en_lfsr_d = 1'b0;
          ledr_d    = '0;
        end
      end
      LIGHT, DELAY: begin
        if (press) begin
          state_d       = FALSE;
          false_start_d = 1'b1;
          ledr_d        = '1;
          en_lfsr_d     = 1'b1;
        end else if (bus.tick_ms && state_q == LIGHT) begin
          if (ms_cnt_q == STEP_LAST) begin
            ms_cnt_d = '0;
            if (step_q == LAST_STEP) begin
              state_d     = DELAY;
              delay_cnt_d = delay_load;
            end else begin
              step_d = step_q + 4'd1;
              ledr_d = therm(step_q + 4'd1);
            end
          end else begin
            ms_cnt_d = ms_cnt_q + 1'b1;
          end
        end else if (bus.tick_ms) begin
          if (delay_cnt_q <= CNT_W'(1)) begin
            state_d     = REACT;
            ledr_d      = '0;
            react_cnt_d = '0;
          end else begin
            delay_cnt_d = delay_cnt_q - 1'b1;
          end
        end
      end
      REACT: begin
        if (press) begin
          state_d        = SHOW;
          react_ms_d     = react_cnt_q;
          result_valid_d = 1'b1;
          timeout_d      = 1'b0;
          en_lfsr_d      = 1'b1;
        end else if (bus.tick_ms) begin
          if (react_cnt_q >= MAX_CNT) begin
            state_d        = SHOW;
            react_ms_d     = MAX_CNT;
            result_valid_d = 1'b1;
            timeout_d      = 1'b1;
            en_lfsr_d      = 1'b1;
          end else begin
            react_cnt_d = react_cnt_q + 1'b1;
          end
        end
      end
      SHOW: begin
        if (press) begin
          state_d   = IDLE;
          timeout_d = 1'b0;
        end
      end
      FALSE: begin
        if (press) begin
          state_d       = IDLE;
          false_start_d = 1'b0;
          ledr_d        = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy         = (state_q == LIGHT) || (state_q == DELAY) || (state_q == REACT);
  assign bus.ledr         = ledr_q;
  assign bus.en_lfsr      = en_lfsr_q;
  assign bus.react_ms     = react_ms_q;
  assign bus.result_valid = result_valid_q;
  assign bus.false_start  = false_start_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl with short timing: STEP_MS=2, MIN_DELAY_MS=3, shift 0, MAX_MS=20.
// Results are predicted into a queue and matched when result_valid pulses.
module tb_reaction_ctrl;
  import reaction_pkg::*;

  localparam int CW   = 14;
  localparam int STEP = 2;
  localparam int MIND = 3;
  localparam int MAXM = 20;
  localparam int LFSR = 5;
  localparam int DLY  = MIND + LFSR;

  typedef struct {
    logic [CW-1:0] ms;
    logic          to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reaction_ctrl_if #(.LFSR_W(7), .CNT_W(CW)) bus ();

  reaction_ctrl #(
    .LFSR_W(7), .STEP_MS(STEP), .MIN_DELAY_MS(MIND),
    .DELAY_SHIFT(0), .MAX_MS(MAXM), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad = 0;
  int   rv_pulses = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Scoreboard: every result_valid pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      rv_pulses++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got react_ms=%0d timeout=%b required no pulse", bus.react_ms, bus.timeout);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.react_ms !== mon_e.ms || bus.timeout !== mon_e.to) begin
          bad++;
          $display("FAIL result got react_ms=%0d timeout=%b required react_ms=%0d timeout=%b",
                   bus.react_ms, bus.timeout, mon_e.ms, mon_e.to);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] therm_exp(int k);
    logic [10:0] w;
    w = (11'd1 << k) - 11'd1;
    return w[9:0];
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      bus.tick_ms = 1'b1;
      @(negedge clk);
      bus.tick_ms = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press_key();
    bus.trigger_n = 1'b0;
    cyc(4);
    bus.trigger_n = 1'b1;
    cyc(4);
  endtask

  // Key low so that the press pulse lands in the same cycle as a tick.
  task automatic press_tick();
    bus.trigger_n = 1'b0;
    cyc(2);
    bus.tick_ms = 1'b1;
    cyc(1);
    bus.tick_ms = 1'b0;
    cyc(2);
    bus.trigger_n = 1'b1;
    cyc(4);
  endtask

  // Leaves the DUT in DELAY with one hold-off tick remaining.
  task automatic go_to_delay_last();
    press_key();
    tick(STEP * NUM_LEDS + STEP + DLY - 1);
  endtask

  task automatic test_reset();
    bus.trigger_n = 1'b1;
    bus.tick_ms   = 1'b0;
    bus.lfsr_val  = 7'(LFSR);
    rst_n = 1'b0;
    cyc(3);
    total++;
    if (bus.ledr !== 10'h000 || bus.en_lfsr !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_lamps got ledr=%h en=%b busy=%b required 000 1 0", bus.ledr, bus.en_lfsr, bus.busy);
    end
    total++;
    if (bus.react_ms !== '0 || bus.result_valid !== 1'b0 || bus.false_start !== 1'b0 || bus.timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_result got ms=%0d rv=%b fs=%b to=%b required 0 0 0 0",
               bus.react_ms, bus.result_valid, bus.false_start, bus.timeout);
    end
    rst_n = 1'b1;
    cyc(3);
    total++;
    if (bus.busy !== 1'b0 || bus.ledr !== 10'h000) begin
      bad++;
      $display("FAIL post_reset_idle got busy=%b ledr=%h required 0 000", bus.busy, bus.ledr);
    end
  endtask

  task automatic test_normal_run();
    int p0;
    p0 = rv_pulses;
    press_key();
    total++;
    if (bus.busy !== 1'b1 || bus.en_lfsr !== 1'b0 || bus.ledr !== 10'h000) begin
      bad++;
      $display("FAIL light_entry got busy=%b en=%b ledr=%h required 1 0 000", bus.busy, bus.en_lfsr, bus.ledr);
    end
    for (int k = 1; k <= NUM_LEDS; k++) begin
      tick(STEP);
      total++;
      if (bus.ledr !== therm_exp(k)) begin
        bad++;
        $display("FAIL led_step%0d got %h required %h", k, bus.ledr, therm_exp(k));
      end
    end
    tick(STEP + DLY - 1);
    total++;
    if (bus.ledr !== 10'h3FF || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL delay_hold got ledr=%h busy=%b required 3ff 1", bus.ledr, bus.busy);
    end
    tick(1);
    total++;
    if (bus.ledr !== 10'h000 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL react_entry got ledr=%h busy=%b required 000 1", bus.ledr, bus.busy);
    end
    tick(7);
    exp_q.push_back('{ms: CW'(7), to: 1'b0});
    press_key();
    total++;
    if (bus.react_ms !== CW'(7) || bus.timeout !== 1'b0 || bus.busy !== 1'b0 || bus.en_lfsr !== 1'b1) begin
      bad++;
      $display("FAIL show got ms=%0d to=%b busy=%b en=%b required 7 0 0 1",
               bus.react_ms, bus.timeout, bus.busy, bus.en_lfsr);
    end
    total++;
    if (rv_pulses !== p0 + 1) begin
      bad++;
      $display("FAIL normal_pulses got %0d required %0d", rv_pulses - p0, 1);
    end
    press_key();
    total++;
    if (bus.react_ms !== CW'(7) || bus.busy !== 1'b0 || bus.ledr !== 10'h000) begin
      bad++;
      $display("FAIL retain_idle got ms=%0d busy=%b ledr=%h required 7 0 000", bus.react_ms, bus.busy, bus.ledr);
    end
  endtask

  task automatic test_false_start();
    press_key();
    tick(4 * STEP);
    total++;
    if (bus.ledr !== 10'h00F) begin
      bad++;
      $display("FAIL fs_pre got ledr=%h required 00f", bus.ledr);
    end
    press_key();
    total++;
    if (bus.false_start !== 1'b1 || bus.ledr !== 10'h3FF || bus.busy !== 1'b0 || bus.en_lfsr !== 1'b1) begin
      bad++;
      $display("FAIL fs_enter got fs=%b ledr=%h busy=%b en=%b required 1 3ff 0 1",
               bus.false_start, bus.ledr, bus.busy, bus.en_lfsr);
    end
    press_key();
    total++;
    if (bus.false_start !== 1'b0 || bus.ledr !== 10'h000 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL fs_exit got fs=%b ledr=%h busy=%b required 0 000 0", bus.false_start, bus.ledr, bus.busy);
    end
  endtask

  task automatic test_saturation();
    int p0;
    go_to_delay_last();
    tick(1);
    p0 = rv_pulses;
    tick(MAXM);
    total++;
    if (bus.busy !== 1'b1 || bus.timeout !== 1'b0 || rv_pulses !== p0) begin
      bad++;
      $display("FAIL sat_pre got busy=%b to=%b pulses=%0d required 1 0 0", bus.busy, bus.timeout, rv_pulses - p0);
    end
    exp_q.push_back('{ms: CW'(MAXM), to: 1'b1});
    tick(1);
    total++;
    if (bus.busy !== 1'b0 || bus.timeout !== 1'b1 || bus.react_ms !== CW'(MAXM) || bus.en_lfsr !== 1'b1) begin
      bad++;
      $display("FAIL sat_show got busy=%b to=%b ms=%0d en=%b required 0 1 %0d 1",
               bus.busy, bus.timeout, bus.react_ms, bus.en_lfsr, MAXM);
    end
    tick(5);
    total++;
    if (rv_pulses !== p0 + 1) begin
      bad++;
      $display("FAIL sat_pulses got %0d required 1", rv_pulses - p0);
    end
    press_key();
    total++;
    if (bus.timeout !== 1'b0 || bus.react_ms !== CW'(MAXM)) begin
      bad++;
      $display("FAIL sat_exit got to=%b ms=%0d required 0 %0d", bus.timeout, bus.react_ms, MAXM);
    end
  endtask

  task automatic test_coincident();
    int p0;
    go_to_delay_last();
    tick(1);
    tick(4);
    exp_q.push_back('{ms: CW'(4), to: 1'b0});
    press_tick();
    total++;
    if (bus.react_ms !== CW'(4) || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL coinc_react got ms=%0d busy=%b required 4 0", bus.react_ms, bus.busy);
    end
    press_key();
    p0 = rv_pulses;
    go_to_delay_last();
    press_tick();
    total++;
    if (bus.false_start !== 1'b1 || bus.busy !== 1'b0 || bus.ledr !== 10'h3FF || rv_pulses !== p0) begin
      bad++;
      $display("FAIL coinc_delay got fs=%b busy=%b ledr=%h pulses=%0d required 1 0 3ff 0",
               bus.false_start, bus.busy, bus.ledr, rv_pulses - p0);
    end
    press_key();
  endtask

  task automatic test_async_reset();
    int p0;
    go_to_delay_last();
    tick(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.ledr !== 10'h000 || bus.en_lfsr !== 1'b1 || bus.react_ms !== '0 ||
        bus.result_valid !== 1'b0 || bus.false_start !== 1'b0 || bus.timeout !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got busy=%b ledr=%h en=%b ms=%0d rv=%b fs=%b to=%b required 0 000 1 0 0 0 0",
               bus.busy, bus.ledr, bus.en_lfsr, bus.react_ms, bus.result_valid, bus.false_start, bus.timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    p0 = rv_pulses;
    tick(MAXM + 5);
    cyc(3);
    total++;
    if (rv_pulses !== p0 || bus.busy !== 1'b0 || bus.ledr !== 10'h000) begin
      bad++;
      $display("FAIL after_reset got pulses=%0d busy=%b ledr=%h required 0 0 000", rv_pulses - p0, bus.busy, bus.ledr);
    end
  endtask

  task automatic test_press_held();
    int extra;
    bus.trigger_n = 1'b0;
    cyc(2);
    total++;
    if (dut.u_sync.press_o !== 1'b1 || bus.en_lfsr !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL press_latency got press=%b en=%b busy=%b required 1 1 0",
               dut.u_sync.press_o, bus.en_lfsr, bus.busy);
    end
    cyc(1);
    total++;
    if (dut.u_sync.press_o !== 1'b0 || bus.en_lfsr !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL en_lfsr_fall got press=%b en=%b busy=%b required 0 0 1",
               dut.u_sync.press_o, bus.en_lfsr, bus.busy);
    end
    extra = 0;
    for (int i = 0; i < 47; i++) begin
      @(negedge clk);
      if (dut.u_sync.press_o === 1'b1) extra++;
    end
    total++;
    if (extra !== 0 || bus.busy !== 1'b1 || bus.false_start !== 1'b0) begin
      bad++;
      $display("FAIL held_key got extra=%0d busy=%b fs=%b required 0 1 0", extra, bus.busy, bus.false_start);
    end
    bus.trigger_n = 1'b1;
    cyc(4);
    press_key();
    total++;
    if (bus.false_start !== 1'b1) begin
      bad++;
      $display("FAIL held_exit_fs got %b required 1", bus.false_start);
    end
    press_key();
    total++;
    if (bus.false_start !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL held_exit_idle got fs=%b busy=%b required 0 0", bus.false_start, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_false_start();
    test_saturation();
    test_coincident();
    test_async_reset();
    test_press_held();
    cyc(4);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_results got %0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
